// File: rtl/moddiv_seq_ctrl_if.sv
// Handshake and status bundle between the modular-division sequencer and its
// surroundings (requester, u/v/x1/x2 datapath, b-location flag register).
// master: the side that requests runs and supplies datapath status/ack.
// slave : the sequencer itself.
interface moddiv_seq_ctrl_if #(
    parameter int CNT_W = 10
);
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    logic             u_even;
    logic             v_even;
    logic             u_gt_v;
    logic             u_is_one;
    logic             v_is_one;
    logic [2:0]       op;
    logic             op_vld;
    logic             dp_ack;
    logic             mmul_en;
    logic [1:0]       b_flag_in;
    logic             b_flag_we;
    logic [CNT_W-1:0] iter_cnt;

    modport master (
        output start, u_even, v_even, u_gt_v, u_is_one, v_is_one, dp_ack,
        input  busy, done, err, op, op_vld, mmul_en, b_flag_in, b_flag_we, iter_cnt
    );

    modport slave (
        input  start, u_even, v_even, u_gt_v, u_is_one, v_is_one, dp_ack,
        output busy, done, err, op, op_vld, mmul_en, b_flag_in, b_flag_we, iter_cnt
    );
endinterface

// File: rtl/moddiv_seq_ctrl.sv
// Iteration sequencer for binary modular division b/a mod p.
// Steps the extended binary-Euclid loop on the u/v/x1/x2 datapath and keeps the
// b-location flag pointing at the register that holds the live result:
// mmul_en forces the flag to "regb" at the start of a run, and a single
// b_flag_we strobe retargets it to regc (x1) or regd (x2) on success.
// An aborted run never writes the flag, so it keeps pointing at regb.
module moddiv_seq_ctrl #(
    parameter int N        = 256,
    parameter int CNT_W    = 10,
    parameter int MAX_ITER = 2 * N
) (
    input  logic              clk,
    input  logic              rst_n,
    moddiv_seq_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_EVAL  = 3'd2;
    localparam logic [2:0] ST_ISSUE = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
    localparam logic [2:0] ST_FLAG  = 3'd5;
    localparam logic [2:0] ST_FIN   = 3'd6;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_INIT   = 3'd1;
    localparam logic [2:0] OP_HALF_U = 3'd2;
    localparam logic [2:0] OP_HALF_V = 3'd3;
    localparam logic [2:0] OP_SUB_UV = 3'd4;
    localparam logic [2:0] OP_SUB_VU = 3'd5;

    localparam logic [1:0] FLAG_REGC = 2'b00;
    localparam logic [1:0] FLAG_REGD = 2'b01;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ITER);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    // Loop step choice once neither u nor v has reached one; u==v falls to SUB_VU.
    function automatic logic [2:0] pick_op(input logic u_ev, input logic v_ev, input logic u_gt);
        logic [2:0] sel;
        if (u_ev) begin
            sel = OP_HALF_U;
        end else if (v_ev) begin
            sel = OP_HALF_V;
        end else if (u_gt) begin
            sel = OP_SUB_UV;
        end else begin
            sel = OP_SUB_VU;
        end
        return sel;
    endfunction

    logic [2:0]       state_r,     state_s;
    logic             busy_r,      busy_s;
    logic             done_r,      done_s;
    logic             err_r,       err_s;
    logic [2:0]       op_r,        op_s;
    logic             op_vld_r,    op_vld_s;
    logic             mmul_en_r,   mmul_en_s;
    logic [1:0]       b_flag_in_r, b_flag_in_s;
    logic             b_flag_we_r, b_flag_we_s;
    logic [CNT_W-1:0] iter_cnt_r,  iter_cnt_s;

    logic             ack_s;

    // A datapath ack only counts while a command is actually outstanding.
    always_comb begin
        ack_s = bus.dp_ack & op_vld_r;
    end

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        state_s     = state_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_s       = err_r;
        op_s        = op_r;
        op_vld_s    = op_vld_r;
        mmul_en_s   = 1'b0;
        b_flag_in_s = 2'b00;
        b_flag_we_s = 1'b0;
        iter_cnt_s  = iter_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s    = ST_INIT;
                    busy_s     = 1'b1;
                    mmul_en_s  = 1'b1;
                    err_s      = 1'b0;
                    iter_cnt_s = CNT_ZERO;
                    op_s       = OP_INIT;
                    op_vld_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                end
            end
            ST_INIT, ST_ISSUE, ST_WAIT: begin
                if (ack_s) begin
                    state_s  = ST_EVAL;
                    op_s     = OP_NOP;
                    op_vld_s = 1'b0;
                end else begin
                    state_s = (state_r == ST_INIT) ? ST_INIT : ST_WAIT;
                end
            end
            ST_EVAL: begin
                if (bus.u_is_one) begin
                    state_s     = ST_FLAG;
                    b_flag_in_s = FLAG_REGC;
                    b_flag_we_s = 1'b1;
                end else if (bus.v_is_one) begin
                    state_s     = ST_FLAG;
                    b_flag_in_s = FLAG_REGD;
                    b_flag_we_s = 1'b1;
                end else if (iter_cnt_r == CNT_MAX) begin
                    state_s = ST_FIN;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else begin
                    state_s    = ST_ISSUE;
                    op_s       = pick_op(bus.u_even, bus.v_even, bus.u_gt_v);
                    op_vld_s   = 1'b1;
                    iter_cnt_s = (iter_cnt_r == CNT_MAX) ? iter_cnt_r : (iter_cnt_r + CNT_ONE);
                end
            end
            ST_FLAG: begin
                state_s = ST_FIN;
                done_s  = 1'b1;
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s  = ST_IDLE;
                busy_s   = 1'b0;
                op_s     = OP_NOP;
                op_vld_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks everything at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            op_r        <= OP_NOP;
            op_vld_r    <= 1'b0;
            mmul_en_r   <= 1'b0;
            b_flag_in_r <= 2'b00;
            b_flag_we_r <= 1'b0;
            iter_cnt_r  <= CNT_ZERO;
        end else begin
            state_r     <= state_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            op_r        <= op_s;
            op_vld_r    <= op_vld_s;
            mmul_en_r   <= mmul_en_s;
            b_flag_in_r <= b_flag_in_s;
            b_flag_we_r <= b_flag_we_s;
            iter_cnt_r  <= iter_cnt_s;
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.op        = op_r;
    assign bus.op_vld    = op_vld_r;
    assign bus.mmul_en   = mmul_en_r;
    assign bus.b_flag_in = b_flag_in_r;
    assign bus.b_flag_we = b_flag_we_r;
    assign bus.iter_cnt  = iter_cnt_r;
endmodule

// File: tb/tb_moddiv_seq_ctrl.sv
// Bench for moddiv_seq_ctrl: an integer model of the u/v/x1/x2 datapath answers
// the sequencer's commands, and the expected op stream / outcome comes from a
// plain-arithmetic binary-Euclid reference plus a modular check of the result.
module tb_moddiv_seq_ctrl;
    localparam int N        = 8;
    localparam int CNT_W    = 6;
    localparam int MAX_ITER = 2 * N;

    logic clk;
    logic rst_n;

    moddiv_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    moddiv_seq_ctrl #(.N(N), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc_g  = 0;

    // stimulus settings (written by the test sequence only)
    int a_g, b_g, p_g, dly_mode;
    bit spur_en, force_g;

    // datapath model state (written by the responder only)
    int u_m, v_m, x1_m, x2_m;
    int ops_q[$];
    int hs_bad, op_idx, last_ack, wcnt, cur_dly, cur_op;
    bit pend, spur_on;

    // reference expectations
    int exp_q[$];
    int exp_flag, exp_iter;
    bit exp_err;

    // per-run observations
    int start_cyc, mmul_cnt, mmul_cyc, we_cnt, we_cyc, flag_val, done_cnt, done_cyc;
    int err_done, iter_done, err_at_init, busy_init, err_after, busy_after, inv_bad, extra_mmul;
    bit timed_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc_g <= cyc_g + 1;

    assign bus.u_is_one = force_g ? 1'b0 : (u_m == 1);
    assign bus.v_is_one = force_g ? 1'b0 : (v_m == 1);
    assign bus.u_even   = force_g ? 1'b0 : (u_m % 2 == 0);
    assign bus.v_even   = force_g ? 1'b0 : (v_m % 2 == 0);
    assign bus.u_gt_v   = force_g ? 1'b1 : (u_m > v_m);

    function automatic int half_mod(input int x, input int p);
        return (x % 2 == 0) ? x / 2 : (x + p) / 2;
    endfunction

    function automatic void apply_op(input int o);
        if (!force_g) begin
            case (o)
                1: begin u_m = a_g; v_m = p_g; x1_m = b_g; x2_m = 0; end
                2: begin u_m = u_m / 2; x1_m = half_mod(x1_m, p_g); end
                3: begin v_m = v_m / 2; x2_m = half_mod(x2_m, p_g); end
                4: begin u_m = u_m - v_m; x1_m = (x1_m - x2_m + p_g) % p_g; end
                5: begin v_m = v_m - u_m; x2_m = (x2_m - x1_m + p_g) % p_g; end
                default: ;
            endcase
        end
    endfunction

    // Datapath responder: acks each command after a chosen delay, applies it once accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.dp_ack = 1'b0; wcnt = 0; pend = 1'b0; spur_on = 1'b0;
        end else begin
            if (bus.mmul_en) begin ops_q.delete(); hs_bad = 0; op_idx = 0; end
            if (spur_on) begin
                bus.dp_ack = 1'b0; spur_on = 1'b0;
            end else if (bus.dp_ack) begin
                if (bus.op_vld !== 1'b0 || bus.op !== 3'd0) hs_bad++;
                last_ack = cyc_g - 1;
                apply_op(cur_op);
                bus.dp_ack = 1'b0; wcnt = 0; pend = 1'b0;
                if (spur_en) begin bus.dp_ack = 1'b1; spur_on = 1'b1; end
            end
            if (bus.op_vld && !bus.dp_ack) begin
                if (!pend) begin
                    pend = 1'b1; cur_op = int'(bus.op); ops_q.push_back(cur_op);
                    if (dly_mode == 100)      cur_dly = (op_idx % 3 == 0) ? 0 : ((op_idx % 3 == 1) ? 1 : 5);
                    else if (dly_mode == 200) cur_dly = $urandom_range(0, 3);
                    else                      cur_dly = dly_mode;
                    op_idx++;
                end else if (int'(bus.op) != cur_op) begin
                    hs_bad++;
                end
                if (wcnt >= cur_dly) bus.dp_ack = 1'b1;
                else wcnt++;
            end
        end
    end

    // Binary-Euclid reference: op stream, final flag target, abort and loop count.
    function automatic void ref_model(input int a, input int p);
        int u = a;
        int v = p;
        int n = 0;
        exp_q.delete(); exp_q.push_back(1);
        exp_err = 1'b0; exp_flag = -1;
        while (1) begin
            if (u == 1) begin exp_flag = 0; break; end
            if (v == 1) begin exp_flag = 1; break; end
            if (n == MAX_ITER) begin exp_err = 1'b1; break; end
            if (u % 2 == 0)      begin exp_q.push_back(2); u = u / 2; end
            else if (v % 2 == 0) begin exp_q.push_back(3); v = v / 2; end
            else if (u > v)      begin exp_q.push_back(4); u = u - v; end
            else                 begin exp_q.push_back(5); v = v - u; end
            n++;
        end
        exp_iter = n;
    endfunction

    function automatic int ops_diff();
        int d = 0;
        if (ops_q.size() != exp_q.size()) return 1000 + ops_q.size();
        for (int i = 0; i < exp_q.size(); i++) if (ops_q[i] != exp_q[i]) d++;
        return d;
    endfunction

    function automatic int result_ok(input int a, input int b, input int p);
        int r = (flag_val == 0) ? x1_m : x2_m;
        return ((r * a) % p == b % p) ? 1 : 0;
    endfunction

    // One full run: pulse start, watch until done (bounded), then a short tail.
    task automatic run_div(input int a, input int b, input int p, input int dmode,
                           input bit spur, input bit frc, input bit extra_start);
        a_g = a; b_g = b; p_g = p; dly_mode = dmode; spur_en = spur; force_g = frc;
        mmul_cnt = 0; we_cnt = 0; done_cnt = 0; inv_bad = 0; extra_mmul = 0;
        flag_val = -1; timed_out = 1'b1; err_done = -1; iter_done = -1; we_cyc = -100;
        @(negedge clk); start_cyc = cyc_g; bus.start = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.start = extra_start && (c == 1);
            if (c == 0) begin err_at_init = bus.err; busy_init = bus.busy; end
            if (bus.mmul_en) begin mmul_cnt++; mmul_cyc = cyc_g; end
            if (bus.b_flag_we) begin
                we_cnt++; we_cyc = cyc_g; flag_val = int'(bus.b_flag_in);
                if (bus.op_vld || bus.mmul_en) inv_bad++;
            end
            if (bus.done) begin
                done_cnt++; done_cyc = cyc_g; err_done = bus.err; iter_done = int'(bus.iter_cnt);
                if (bus.op_vld) inv_bad++;
                timed_out = 1'b0;
                break;
            end
        end
        bus.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin busy_after = bus.busy; err_after = bus.err; end
            if (bus.mmul_en) extra_mmul++;
            if (bus.done) done_cnt++;
            if (bus.b_flag_we) we_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; bus.start = 1'b0; force_g = 1'b0; spur_en = 1'b0; dly_mode = 0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.err, bus.op, bus.op_vld, bus.mmul_en, bus.b_flag_in, bus.b_flag_we, bus.iter_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b op=%0d op_vld=%b mmul_en=%b flag_in=%0d we=%b iter=%0d, required all 0",
                bus.busy, bus.done, bus.err, bus.op, bus.op_vld, bus.mmul_en, bus.b_flag_in, bus.b_flag_we, bus.iter_cnt);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        ref_model(3, 7);
        run_div(3, 1, 7, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout: no done within budget"); end
        n_cmp++; if (ops_diff() != 0) begin n_fail++; $display("FAIL basic_ops: got %0d differences, required 0", ops_diff()); end
        n_cmp++; if (iter_done !== 3) begin n_fail++; $display("FAIL basic_iter: got %0d required 3", iter_done); end
        n_cmp++; if (flag_val !== 1 || we_cnt !== 1) begin n_fail++; $display("FAIL basic_flag: got flag=%0d writes=%0d required 1/1", flag_val, we_cnt); end
        n_cmp++; if (done_cyc - we_cyc !== 1) begin n_fail++; $display("FAIL basic_done_lat: got %0d required 1", done_cyc - we_cyc); end
        n_cmp++; if (we_cyc - last_ack !== 2) begin n_fail++; $display("FAIL basic_flag_lat: got %0d required 2", we_cyc - last_ack); end
        n_cmp++; if (mmul_cyc - start_cyc !== 1 || mmul_cnt !== 1) begin n_fail++; $display("FAIL basic_mmul: got lat=%0d count=%0d required 1/1", mmul_cyc - start_cyc, mmul_cnt); end
        n_cmp++; if (err_done !== 0) begin n_fail++; $display("FAIL basic_err: got %0d required 0", err_done); end
        n_cmp++; if (busy_init !== 1 || busy_after !== 0) begin n_fail++; $display("FAIL basic_busy: got %0d/%0d required 1/0", busy_init, busy_after); end
        n_cmp++; if (result_ok(3, 1, 7) != 1) begin n_fail++; $display("FAIL basic_result: got x2=%0d required 5", x2_m); end
        n_cmp++; if (hs_bad !== 0 || inv_bad !== 0) begin n_fail++; $display("FAIL basic_handshake: got %0d/%0d violations required 0", hs_bad, inv_bad); end
    endtask

    task automatic test_u_one();
        ref_model(1, 7);
        run_div(1, 5, 7, 2, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (ops_diff() != 0 || iter_done !== 0) begin n_fail++; $display("FAIL u_one_ops: got diff=%0d iter=%0d required 0/0", ops_diff(), iter_done); end
        n_cmp++; if (flag_val !== 0 || we_cnt !== 1) begin n_fail++; $display("FAIL u_one_flag: got flag=%0d writes=%0d required 0/1", flag_val, we_cnt); end
        n_cmp++; if (we_cyc - mmul_cyc !== 4) begin n_fail++; $display("FAIL u_one_lat: got %0d required 4", we_cyc - mmul_cyc); end
        n_cmp++; if (result_ok(1, 5, 7) != 1) begin n_fail++; $display("FAIL u_one_result: got x1=%0d required 5", x1_m); end
    endtask

    task automatic test_abort();
        exp_q.delete(); exp_q.push_back(1);
        for (int i = 0; i < MAX_ITER; i++) exp_q.push_back(4);
        run_div(5, 1, 7, 0, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (ops_diff() != 0) begin n_fail++; $display("FAIL abort_ops: got %0d ops required %0d", ops_q.size(), exp_q.size()); end
        n_cmp++; if (iter_done !== MAX_ITER) begin n_fail++; $display("FAIL abort_iter: got %0d required %0d", iter_done, MAX_ITER); end
        n_cmp++; if (err_done !== 1 || done_cnt !== 1) begin n_fail++; $display("FAIL abort_err: got err=%0d done=%0d required 1/1", err_done, done_cnt); end
        n_cmp++; if (we_cnt !== 0) begin n_fail++; $display("FAIL abort_no_flag: got %0d writes required 0", we_cnt); end
        n_cmp++; if (err_after !== 1) begin n_fail++; $display("FAIL abort_err_hold: got %0d required 1", err_after); end
        ref_model(3, 7);
        run_div(3, 1, 7, 1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (err_at_init !== 0 || err_done !== 0) begin n_fail++; $display("FAIL abort_err_clear: got %0d/%0d required 0/0", err_at_init, err_done); end
    endtask

    task automatic test_handshake();
        ref_model(5, 11);
        run_div(5, 3, 11, 100, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (ops_diff() != 0) begin n_fail++; $display("FAIL hs_ops: got %0d differences required 0", ops_diff()); end
        n_cmp++; if (iter_done !== exp_iter) begin n_fail++; $display("FAIL hs_iter: got %0d required %0d", iter_done, exp_iter); end
        n_cmp++; if (hs_bad !== 0) begin n_fail++; $display("FAIL hs_stability: got %0d violations required 0", hs_bad); end
        n_cmp++; if (flag_val !== exp_flag || result_ok(5, 3, 11) != 1) begin n_fail++; $display("FAIL hs_result: got flag=%0d required %0d", flag_val, exp_flag); end
    endtask

    task automatic test_busy_start();
        ref_model(1, 1);
        run_div(1, 0, 1, 0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (mmul_cnt !== 1 || extra_mmul !== 0) begin n_fail++; $display("FAIL busy_start_ignored: got mmul=%0d extra=%0d required 1/0", mmul_cnt, extra_mmul); end
        n_cmp++; if (flag_val !== 0) begin n_fail++; $display("FAIL both_one_flag: got %0d required 0", flag_val); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL busy_start_done: got %0d required 1", done_cnt); end
    endtask

    task automatic test_random();
        int primes[8] = '{7, 11, 13, 31, 61, 101, 127, 251};
        for (int k = 0; k < 8; k++) begin
            int p = primes[$urandom_range(0, 7)];
            int a = $urandom_range(1, p - 1);
            int b = $urandom_range(0, p - 1);
            ref_model(a, p);
            run_div(a, b, p, 200, bit'($urandom_range(0, 1)), 1'b0, 1'b0);
            n_cmp++; if (ops_diff() != 0) begin n_fail++; $display("FAIL rand_ops a=%0d p=%0d: got %0d differences required 0", a, p, ops_diff()); end
            n_cmp++; if (err_done !== int'(exp_err)) begin n_fail++; $display("FAIL rand_err a=%0d p=%0d: got %0d required %0d", a, p, err_done, exp_err); end
            if (!exp_err) begin
                n_cmp++; if (flag_val !== exp_flag || result_ok(a, b, p) != 1) begin n_fail++; $display("FAIL rand_result a=%0d b=%0d p=%0d: got flag=%0d required %0d", a, b, p, flag_val, exp_flag); end
                n_cmp++; if (we_cyc - last_ack !== 2) begin n_fail++; $display("FAIL rand_flag_lat: got %0d required 2", we_cyc - last_ack); end
            end else begin
                n_cmp++; if (we_cnt !== 0) begin n_fail++; $display("FAIL rand_abort_flag: got %0d writes required 0", we_cnt); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        a_g = 3; b_g = 1; p_g = 7; dly_mode = 5; spur_en = 1'b0; force_g = 1'b0;
        @(negedge clk); bus.start = 1'b1;
        for (int c = 0; c < 10; c++) begin @(negedge clk); bus.start = 1'b0; end
        n_cmp++; if (bus.op_vld !== 1'b1 || bus.iter_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL rst_mid_pre: got op_vld=%b iter=%0d required 1/1", bus.op_vld, bus.iter_cnt); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.busy, bus.done, bus.err, bus.op, bus.op_vld, bus.mmul_en, bus.b_flag_in, bus.b_flag_we, bus.iter_cnt} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got busy=%b op_vld=%b op=%0d iter=%0d, required all 0", bus.busy, bus.op_vld, bus.op, bus.iter_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.b_flag_we || bus.done || bus.busy) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_u_one();
        test_abort();
        test_handshake();
        test_busy_start();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
